// File: rtl/parse_act_cfg_ctrl_pkg.sv
// Shared definitions for the parse-action RAM configuration path:
// RAM geometry defaults, ctrl-beat field offsets and FSM state encodings.
package parse_act_cfg_ctrl_pkg;

  localparam int unsigned DEF_ACT_RAM_WIDTH = 260;
  localparam int unsigned DEF_ACT_RAM_DEPTH = 16;

  localparam int unsigned MODID_LSB = 112;
  localparam int unsigned ADDR_LSB  = 128;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_MODID   = 3'd1;
  localparam state_t ST_DATA_HI = 3'd2;
  localparam state_t ST_DATA_LO = 3'd3;
  localparam state_t ST_DRAIN   = 3'd4;

endpackage

// File: rtl/parse_act_cfg_ctrl_axis_byteswap.sv
// Combinational N-byte reversal: output byte i is input byte N-1-i.
module axis_byteswap #(
  parameter int unsigned N_BYTES = 32
) (
  input  logic [8*N_BYTES-1:0] data_i,
  output logic [8*N_BYTES-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < N_BYTES; i++) begin
      data_o[8*i +: 8] = data_i[8*(N_BYTES-1-i) +: 8];
    end
  end

endmodule

// File: rtl/parse_act_cfg_ctrl.sv
// Parse-action RAM config controller: decodes 4-beat ctrl write packets, holds one
// pending entry and commits it to the RAM only while the parser is idle (or on timeout).
module parse_act_cfg_ctrl
  import parse_act_cfg_ctrl_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned ACT_RAM_WIDTH        = DEF_ACT_RAM_WIDTH,
  parameter int unsigned ACT_RAM_DEPTH        = DEF_ACT_RAM_DEPTH,
  parameter logic [2:0]  MOD_ID               = 3'b0,
  parameter int unsigned COMMIT_TIMEOUT       = 15
) (
  input  logic                                 axis_clk,
  input  logic                                 aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       ctrl_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      ctrl_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     ctrl_s_axis_tkeep,
  input  logic                                 ctrl_s_axis_tvalid,
  input  logic                                 ctrl_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       ctrl_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      ctrl_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     ctrl_m_axis_tkeep,
  output logic                                 ctrl_m_axis_tvalid,
  output logic                                 ctrl_m_axis_tlast,
  input  logic                                 parser_busy,
  output logic                                 ram_wr_en,
  output logic [$clog2(ACT_RAM_DEPTH)-1:0]     ram_wr_addr,
  output logic [ACT_RAM_WIDTH-1:0]             ram_wr_data,
  output logic                                 cfg_done,
  output logic                                 cfg_err,
  output logic [15:0]                          cfg_wr_cnt
);

  localparam int unsigned AW        = $clog2(ACT_RAM_DEPTH);
  localparam int unsigned LO_W      = ACT_RAM_WIDTH - C_S_AXIS_DATA_WIDTH;
  localparam logic [7:0]  DEPTH_LIM = 8'(ACT_RAM_DEPTH);
  localparam logic [3:0]  TIMEOUT   = 4'(COMMIT_TIMEOUT);

  logic [C_S_AXIS_DATA_WIDTH-1:0] swapped;

  axis_byteswap #(
    .N_BYTES (C_S_AXIS_DATA_WIDTH / 8)
  ) u_swap (
    .data_i (ctrl_s_axis_tdata),
    .data_o (swapped)
  );

  // Forwarding path: registered copy of every beat, matched or not.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      ctrl_m_axis_tdata  <= '0;
      ctrl_m_axis_tuser  <= '0;
      ctrl_m_axis_tkeep  <= '0;
      ctrl_m_axis_tvalid <= 1'b0;
      ctrl_m_axis_tlast  <= 1'b0;
    end else begin
      ctrl_m_axis_tdata  <= ctrl_s_axis_tdata;
      ctrl_m_axis_tuser  <= ctrl_s_axis_tuser;
      ctrl_m_axis_tkeep  <= ctrl_s_axis_tkeep;
      ctrl_m_axis_tvalid <= ctrl_s_axis_tvalid;
      ctrl_m_axis_tlast  <= ctrl_s_axis_tlast;
    end
  end

  state_t                         state_q, state_d;
  logic [AW-1:0]                  addr_q, addr_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0] hi_q, hi_d;
  logic                           load, fsm_err;
  logic [7:0]                     addr_field;
  logic                           id_match;

  assign addr_field = ctrl_s_axis_tdata[ADDR_LSB +: 8];
  assign id_match   = (ctrl_s_axis_tdata[MODID_LSB +: 3] == MOD_ID);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    load    = 1'b0;
    fsm_err = 1'b0;
    if (ctrl_s_axis_tvalid) begin
      case (state_q)
        ST_IDLE: if (!ctrl_s_axis_tlast) state_d = ST_MODID;
        ST_MODID: begin
          if (id_match) begin
            addr_d = addr_field[AW-1:0];
            if (ctrl_s_axis_tlast) begin
              fsm_err = 1'b1;
              state_d = ST_IDLE;
            end else if (addr_field >= DEPTH_LIM) begin
              fsm_err = 1'b1;
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_DATA_HI;
            end
          end else begin
            state_d = ctrl_s_axis_tlast ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_DATA_HI: begin
          if (ctrl_s_axis_tlast) begin
            fsm_err = 1'b1;
            state_d = ST_IDLE;
          end else begin
            hi_d    = swapped;
            state_d = ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          load    = 1'b1;
          state_d = ctrl_s_axis_tlast ? ST_IDLE : ST_DRAIN;
        end
        ST_DRAIN: if (ctrl_s_axis_tlast) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
    end
  end

  logic                     pend_valid_q, pend_valid_d;
  logic [AW-1:0]            pend_addr_q, pend_addr_d;
  logic [ACT_RAM_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [3:0]               wait_cnt_q, wait_cnt_d;
  logic                     commit, drop;
  logic                     wr_en_q, err_q;
  logic [AW-1:0]            wr_addr_q;
  logic [ACT_RAM_WIDTH-1:0] wr_data_q;
  logic [15:0]              wr_cnt_q;

  assign commit = pend_valid_q && (!parser_busy || (wait_cnt_q == TIMEOUT));
  // A commit in the same cycle frees the slot, so the new entry is accepted.
  assign drop   = load && pend_valid_q && !commit;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    wait_cnt_d   = wait_cnt_q;
    if (commit) begin
      pend_valid_d = 1'b0;
    end else if (pend_valid_q && parser_busy) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    if (load && !drop) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = addr_q;
      pend_data_d  = {hi_q, swapped[C_S_AXIS_DATA_WIDTH-1 -: LO_W]};
      wait_cnt_d   = '0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      wait_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      err_q        <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      wait_cnt_q   <= wait_cnt_d;
      wr_en_q      <= commit;
      err_q        <= fsm_err | drop;
      if (commit) begin
        wr_addr_q <= pend_addr_q;
        wr_data_q <= pend_data_q;
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      wr_cnt_q <= '0;
    end else if (commit && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign cfg_done    = wr_en_q;
  assign cfg_err     = err_q;
  assign cfg_wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_parse_act_cfg_ctrl.sv
// Bench for parse_act_cfg_ctrl: table of packets plus hand-built timing/reset sequences,
// expected RAM writes queued at drive time and popped when ram_wr_en fires.
`timescale 1ns/1ps
module tb_parse_act_cfg_ctrl;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = 32;
  localparam int RW = 260;

  logic          axis_clk = 1'b0;
  logic          aresetn  = 1'b0;
  logic [DW-1:0] ctrl_s_axis_tdata  = '0;
  logic [UW-1:0] ctrl_s_axis_tuser  = '0;
  logic [KW-1:0] ctrl_s_axis_tkeep  = '0;
  logic          ctrl_s_axis_tvalid = 1'b0;
  logic          ctrl_s_axis_tlast  = 1'b0;
  logic [DW-1:0] ctrl_m_axis_tdata;
  logic [UW-1:0] ctrl_m_axis_tuser;
  logic [KW-1:0] ctrl_m_axis_tkeep;
  logic          ctrl_m_axis_tvalid;
  logic          ctrl_m_axis_tlast;
  logic          parser_busy = 1'b0;
  logic          ram_wr_en;
  logic [3:0]    ram_wr_addr;
  logic [RW-1:0] ram_wr_data;
  logic          cfg_done;
  logic          cfg_err;
  logic [15:0]   cfg_wr_cnt;

  parse_act_cfg_ctrl #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .ACT_RAM_WIDTH        (RW),
    .ACT_RAM_DEPTH        (16),
    .MOD_ID               (3'b000),
    .COMMIT_TIMEOUT       (15)
  ) dut (
    .axis_clk           (axis_clk),
    .aresetn            (aresetn),
    .ctrl_s_axis_tdata  (ctrl_s_axis_tdata),
    .ctrl_s_axis_tuser  (ctrl_s_axis_tuser),
    .ctrl_s_axis_tkeep  (ctrl_s_axis_tkeep),
    .ctrl_s_axis_tvalid (ctrl_s_axis_tvalid),
    .ctrl_s_axis_tlast  (ctrl_s_axis_tlast),
    .ctrl_m_axis_tdata  (ctrl_m_axis_tdata),
    .ctrl_m_axis_tuser  (ctrl_m_axis_tuser),
    .ctrl_m_axis_tkeep  (ctrl_m_axis_tkeep),
    .ctrl_m_axis_tvalid (ctrl_m_axis_tvalid),
    .ctrl_m_axis_tlast  (ctrl_m_axis_tlast),
    .parser_busy        (parser_busy),
    .ram_wr_en          (ram_wr_en),
    .ram_wr_addr        (ram_wr_addr),
    .ram_wr_data        (ram_wr_data),
    .cfg_done           (cfg_done),
    .cfg_err            (cfg_err),
    .cfg_wr_cnt         (cfg_wr_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          err_seen = 0;
  int          wr_seen = 0;
  int unsigned last_wr_cyc = 0;
  int          exp_cnt = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    logic [3:0]    addr;
    logic [RW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  always @(posedge axis_clk) cyc <= cyc + 1;

  // One-cycle delay reference for the forwarded stream.
  logic [DW+UW+KW+1:0] fwd_exp;
  always @(posedge axis_clk) begin
    if (!aresetn) fwd_exp <= '0;
    else fwd_exp <= {ctrl_s_axis_tdata, ctrl_s_axis_tuser, ctrl_s_axis_tkeep,
                     ctrl_s_axis_tvalid, ctrl_s_axis_tlast};
  end

  always @(negedge axis_clk) begin
    if (mon_en) begin
      checks++;
      if ({ctrl_m_axis_tdata, ctrl_m_axis_tuser, ctrl_m_axis_tkeep,
           ctrl_m_axis_tvalid, ctrl_m_axis_tlast} !== fwd_exp) begin
        errors++;
        $display("FAIL fwd cyc=%0d got_valid=%b exp_valid=%b got_last=%b exp_last=%b",
                 cyc, ctrl_m_axis_tvalid, fwd_exp[1], ctrl_m_axis_tlast, fwd_exp[0]);
      end
      if (ram_wr_en !== 1'b0 || cfg_done !== 1'b0) begin
        checks++;
        if (cfg_done !== ram_wr_en) begin
          errors++;
          $display("FAIL done_vs_wr got_done=%b exp=%b", cfg_done, ram_wr_en);
        end
      end
      if (cfg_err === 1'b1) err_seen++;
      if (ram_wr_en === 1'b1) begin
        wr_seen++;
        last_wr_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got_addr=%0d exp=none", ram_wr_addr);
        end else begin
          mon_e = exp_q.pop_front();
          checks++;
          if (ram_wr_addr !== mon_e.addr) begin
            errors++;
            $display("FAIL wr_addr got=%0d exp=%0d", ram_wr_addr, mon_e.addr);
          end
          checks++;
          if (ram_wr_data !== mon_e.data) begin
            errors++;
            $display("FAIL wr_data got=%h exp=%h", ram_wr_data, mon_e.data);
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] bswap(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < DW/8; i++) r[8*i +: 8] = d[8*(DW/8-1-i) +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last);
    ctrl_s_axis_tdata  = d;
    ctrl_s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
    ctrl_s_axis_tkeep  = $urandom;
    ctrl_s_axis_tvalid = 1'b1;
    ctrl_s_axis_tlast  = last;
    tick();
    ctrl_s_axis_tvalid = 1'b0;
    ctrl_s_axis_tlast  = 1'b0;
  endtask

  // Invalid cycle with garbage tlast/tdata that the FSM must ignore.
  task automatic bubble();
    ctrl_s_axis_tdata  = rnd256();
    ctrl_s_axis_tvalid = 1'b0;
    ctrl_s_axis_tlast  = 1'b1;
    tick();
    ctrl_s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] id, input logic [7:0] addr, input int nbeats,
                          input bit gap, input bit pat, input bit exp_wr, input bit rel_busy);
    logic [DW-1:0] b [8];
    logic [DW-1:0] s3;
    wr_t e;
    for (int i = 0; i < 8; i++) b[i] = rnd256();
    b[1][114:112] = id;
    b[1][135:128] = addr;
    if (pat) for (int k = 0; k < DW/8; k++) b[2][8*k +: 8] = 8'hA5 ^ 8'(k);
    if (exp_wr) begin
      s3     = bswap(b[3]);
      e.addr = addr[3:0];
      e.data = {bswap(b[2]), s3[DW-1 -: 4]};
      exp_q.push_back(e);
      exp_cnt++;
    end
    for (int i = 0; i < nbeats; i++) begin
      if (rel_busy && i == nbeats-1) parser_busy = 1'b0;
      beat(b[i], (i == nbeats-1));
      if (gap && i < nbeats-1) bubble();
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    checks++;
    if (ram_wr_en !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0 || cfg_wr_cnt !== 16'd0 ||
        ram_wr_addr !== 4'd0 || ram_wr_data !== '0 || ctrl_m_axis_tvalid !== 1'b0 ||
        ctrl_m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL %s got wr_en=%b err=%b cnt=%0d addr=%0d mvalid=%b exp all zero",
               nm, ram_wr_en, cfg_err, cfg_wr_cnt, ram_wr_addr, ctrl_m_axis_tvalid);
    end
  endtask

  typedef struct {
    logic [2:0] id;
    logic [7:0] addr;
    int         nbeats;
    bit         gap;
    bit         pat;
    bit         exp_wr;
    int         exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    int e0, w0;
    int unsigned c0;
    logic [DW-1:0] pb;

    vecs[0]  = '{3'd0, 8'd5,   4, 1'b0, 1'b1, 1'b1, 0};
    vecs[1]  = '{3'd0, 8'd15,  4, 1'b1, 1'b0, 1'b1, 0};
    vecs[2]  = '{3'd0, 8'd16,  4, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'd0, 8'd20,  4, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'd3, 8'd5,   4, 1'b1, 1'b0, 1'b0, 0};
    vecs[5]  = '{3'd0, 8'd0,   3, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'd0, 8'd0,   4, 1'b1, 1'b1, 1'b1, 0};
    vecs[7]  = '{3'd0, 8'd7,   2, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'd3, 8'd7,   2, 1'b0, 1'b0, 1'b0, 0};
    vecs[9]  = '{3'd0, 8'd9,   1, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{3'd0, 8'd12,  6, 1'b1, 1'b0, 1'b1, 0};
    vecs[11] = '{3'd5, 8'd200, 5, 1'b0, 1'b0, 1'b0, 0};

    repeat (3) tick();
    mon_en = 1'b1;
    chk_reset_outputs("reset_state");
    aresetn = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      e0 = err_seen;
      w0 = wr_seen;
      send_pkt(vecs[i].id, vecs[i].addr, vecs[i].nbeats, vecs[i].gap, vecs[i].pat,
               vecs[i].exp_wr, 1'b0);
      repeat (4) tick();
      chk($sformatf("vec%0d_err", i), err_seen - e0, vecs[i].exp_err);
      chk($sformatf("vec%0d_wr", i), wr_seen - w0, vecs[i].exp_wr ? 1 : 0);
      chk($sformatf("vec%0d_cnt", i), int'(cfg_wr_cnt), exp_cnt);
    end

    // Earliest commit: one cycle after the DATA_LO beat is taken.
    send_pkt(3'd0, 8'd5, 4, 1'b0, 1'b1, 1'b1, 1'b0);
    c0 = cyc;
    repeat (4) tick();
    chk("lat_idle", int'(last_wr_cyc - c0), 1);

    // Busy for three cycles delays the commit by exactly three.
    send_pkt(3'd0, 8'd5, 4, 1'b0, 1'b1, 1'b1, 1'b0);
    c0 = cyc;
    parser_busy = 1'b1;
    repeat (3) tick();
    parser_busy = 1'b0;
    repeat (4) tick();
    chk("lat_busy3", int'(last_wr_cyc - c0), 4);

    // Busy stuck: forced commit once wait_cnt reaches the timeout.
    w0 = wr_seen;
    send_pkt(3'd0, 8'd11, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    c0 = cyc;
    parser_busy = 1'b1;
    repeat (22) tick();
    parser_busy = 1'b0;
    tick();
    chk("timeout_wr", wr_seen - w0, 1);
    chk("timeout_lat", int'(last_wr_cyc - c0), 16);

    // Back-to-back with busy held: second entry dropped.
    e0 = err_seen;
    w0 = wr_seen;
    send_pkt(3'd0, 8'd2, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    parser_busy = 1'b1;
    send_pkt(3'd0, 8'd3, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    parser_busy = 1'b0;
    repeat (4) tick();
    chk("b2b_drop_err", err_seen - e0, 1);
    chk("b2b_drop_wr", wr_seen - w0, 1);

    // Busy falls on the second load edge: old commits, new becomes pending.
    e0 = err_seen;
    w0 = wr_seen;
    send_pkt(3'd0, 8'd10, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    parser_busy = 1'b1;
    send_pkt(3'd0, 8'd14, 4, 1'b0, 1'b0, 1'b1, 1'b1);
    c0 = cyc;
    repeat (4) tick();
    chk("ldcommit_err", err_seen - e0, 0);
    chk("ldcommit_wr", wr_seen - w0, 2);
    chk("ldcommit_lat", int'(last_wr_cyc - c0), 1);
    chk("ldcommit_cnt", int'(cfg_wr_cnt), exp_cnt);

    // Reset while in DATA_HI: partial packet discarded.
    w0 = wr_seen;
    e0 = err_seen;
    pb = rnd256();
    beat(rnd256(), 1'b0);
    pb[114:112] = 3'd0;
    pb[135:128] = 8'd4;
    beat(pb, 1'b0);
    aresetn = 1'b0;
    tick();
    chk_reset_outputs("reset_data_hi");
    exp_cnt = 0;
    tick();
    aresetn = 1'b1;
    pb = rnd256();
    beat(pb, 1'b0);
    pb = rnd256();
    pb[114:112] = 3'd7;
    beat(pb, 1'b1);
    repeat (4) tick();
    chk("rst_hi_wr", wr_seen - w0, 0);
    chk("rst_hi_err", err_seen - e0, 0);

    // Reset while an entry is pending: no write afterwards.
    w0 = wr_seen;
    send_pkt(3'd0, 8'd6, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    parser_busy = 1'b1;
    repeat (2) tick();
    aresetn = 1'b0;
    tick();
    chk_reset_outputs("reset_pending");
    tick();
    aresetn = 1'b1;
    parser_busy = 1'b0;
    repeat (5) tick();
    chk("rst_pend_wr", wr_seen - w0, 0);
    chk("rst_pend_cnt", int'(cfg_wr_cnt), 0);

    // Normal operation after reset.
    send_pkt(3'd0, 8'd1, 4, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    chk("post_rst_cnt", int'(cfg_wr_cnt), exp_cnt);
    chk("queue_empty", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
